ram_march_bist: RTL
===================

Name: ram_march_bist

Overview:
- Built-in self-test controller that sits directly upstream of the 256x32 RAM.
- Drives the RAM's WR, address and Din ports and checks its Dout during a March C- style sequence.
- Reports pass/fail, first failing address and data, and an error count to the test/debug logic.
- When BUSY is low, the functional path owns the RAM; the port mux is outside this block.

Parameters:
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W.
- DATA_W, 32, RAM data width.
- RD_LAT, 1, number of rising edges between a read's issuing edge and the edge where Dout is valid for comparison (0 = combinational read).
- BG_PAT, 32'h0000_0000, background pattern P0; P1 = ~P0.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin the test; sampled only in IDLE.
- WR  out  1  RAM write enable.
- address  out  ADDR_W  RAM address.
- Din  out  DATA_W  RAM write data.
- Dout  in  DATA_W  RAM read data.
- BUSY  out  1  high while the test runs, including the drain.
- DONE  out  1  level; high from test completion until the next accepted START.
- FAIL  out  1  sticky; set on any miscompare in the current run.
- FAIL_ADDR  out  ADDR_W  address of the first miscompare.
- FAIL_DATA  out  DATA_W  XOR of Dout and expected data at the first miscompare.
- ERR_COUNT  out  8  number of miscompares, saturating at 255.

Behaviour:
- Reset (async, RST_N=0):
  - State IDLE.
  - WR=0, address=0, Din=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, FAIL_DATA=0, ERR_COUNT=0.
  - Compare pipeline is flushed.
  - Reset mid-run aborts immediately; no further RAM writes occur.
- States: IDLE, M0, M1_RD, M1_WR, M2_RD, M2_WR, M3, DRAIN, FIN.
- IDLE:
  - WR=0, address=0, Din=0.
  - START=1 at an edge moves to M0 with address 0.
  - The same edge clears FAIL, FAIL_ADDR, FAIL_DATA, ERR_COUNT and DONE, and sets BUSY.
- M0 (ascending): one cycle per address, WR=1, Din=P0.
- M1 (ascending):
  - M1_RD: WR=0, expect P0.
  - M1_WR: WR=1, Din=P1, same address, then address+1.
- M2 (descending from 2^ADDR_W-1):
  - M2_RD: expect P1.
  - M2_WR: Din=P0, then address-1.
- M3 (descending): WR=0, expect P0, one cycle per address.
- Element boundaries:
  - At the last address, move to the next element with no idle cycle.
  - Address reloads to 0 for ascending elements and to the max address for descending ones.
  - Counter wrap is never exposed on the port.
- DRAIN: WR=0, address held at 0, RD_LAT cycles, so the final reads get compared; skipped when RD_LAT=0.
- FIN: one cycle; BUSY drops, DONE is set, then return to IDLE.
- Total BUSY duration = 6*2^ADDR_W + RD_LAT cycles (1537 at defaults).
- Compare pipeline:
  - Each read cycle pushes {valid, address, expected} into an RD_LAT-deep shift register.
  - At the output stage, valid && (Dout != expected) counts as a miscompare.
  - The first miscompare of a run loads FAIL_ADDR and FAIL_DATA; later ones only increment ERR_COUNT and keep FAIL set.
  - Write cycles push valid=0.
- START while BUSY, or in the FIN cycle, is ignored.
- FAIL, FAIL_ADDR, FAIL_DATA and ERR_COUNT hold their values after DONE until the next accepted START or reset.

Test Plan:
- Ideal RAM model, RD_LAT=1, START pulse:
  - BUSY high for exactly 1537 cycles.
  - First 256 cycles: WR=1, address 0..255, Din=0.
  - Cycle 257: WR=0, address 0. Cycle 258: WR=1, Din=FFFF_FFFF.
  - End: DONE=1, FAIL=0, ERR_COUNT=0.
- RAM model with address 0x36 bit 3 stuck at 1:
  - FAIL=1, FAIL_ADDR=0x36, FAIL_DATA=0x0000_0008, ERR_COUNT=2 (miscompares in M1 and M3).
- Address 0x5C bit 0 stuck at 0:
  - FAIL_ADDR=0x5C, FAIL_DATA=0x0000_0001, ERR_COUNT=1 (M2 only).
- START re-asserted at cycle 100 of a run:
  - Ignored; the address sequence and total duration are unchanged.
- RST_N low at cycle 700:
  - All outputs go to their reset values immediately, with no WR after reset.
  - A subsequent START runs a full clean pass.
- RD_LAT=2 build, injected fault at 0xD7 (all bits inverted on reads):
  - BUSY lasts 1538 cycles.
  - FAIL_ADDR=0xD7, ERR_COUNT=3.
  - The last M3 read (address 0) is still compared during DRAIN.

Source files
------------

// File: rtl/ram_march_bist.sv
// March C- BIST controller for a single-port RAM: drives WR/address/Din,
// checks Dout through an RD_LAT-deep compare pipeline and logs failures.
module ram_march_bist #(
  parameter int                 ADDR_W = 8,
  parameter int                 DATA_W = 32,
  parameter int                 RD_LAT = 1,
  parameter logic [DATA_W-1:0]  BG_PAT = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              WR,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] Din,
  input  logic [DATA_W-1:0] Dout,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_DATA,
  output logic [7:0]        ERR_COUNT,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    IDLE, M0, M1_RD, M1_WR, M2_RD, M2_WR, M3, DRAIN, FIN
  } state_t;

  localparam logic [DATA_W-1:0] P0         = BG_PAT;
  localparam logic [DATA_W-1:0] P1         = ~BG_PAT;
  localparam logic [ADDR_W-1:0] AMAX       = '1;
  localparam logic [ADDR_W-1:0] AONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t              state, nxt;
  logic [ADDR_W-1:0]   cnt, nxt_cnt, nxt_addr;
  logic                nxt_wr, nxt_rd, nxt_busy;
  logic [DATA_W-1:0]   nxt_din, nxt_exp;
  logic                rd_v, cmp_v;
  logic [ADDR_W-1:0]   rd_a, cmp_a;
  logic [DATA_W-1:0]   rd_e, cmp_e;

  assign state_dbg = state;

  // START is a bare one-cycle request: no ready, accepted only when IDLE.
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    case (state)
      IDLE:  begin nxt_cnt = '0; if (START) nxt = M0; end
      M0:    if (cnt == AMAX) begin nxt = M1_RD; nxt_cnt = '0; end
             else nxt_cnt = cnt + AONE;
      M1_RD: nxt = M1_WR;
      M1_WR: if (cnt == AMAX) begin nxt = M2_RD; nxt_cnt = AMAX; end
             else begin nxt = M1_RD; nxt_cnt = cnt + AONE; end
      M2_RD: nxt = M2_WR;
      M2_WR: if (cnt == '0) begin nxt = M3; nxt_cnt = AMAX; end
             else begin nxt = M2_RD; nxt_cnt = cnt - AONE; end
      M3:    if (cnt == '0) nxt = (RD_LAT == 0) ? FIN : DRAIN;
             else nxt_cnt = cnt - AONE;
      DRAIN: if (cnt == DRAIN_LAST) begin nxt = FIN; nxt_cnt = '0; end
             else nxt_cnt = cnt + AONE;
      FIN:   begin nxt = IDLE; nxt_cnt = '0; end
      default: begin nxt = IDLE; nxt_cnt = '0; end
    endcase
  end

  // Port values are registered from the next state so they line up with it.
  always_comb begin
    nxt_wr   = (nxt == M0) || (nxt == M1_WR) || (nxt == M2_WR);
    nxt_rd   = (nxt == M1_RD) || (nxt == M2_RD) || (nxt == M3);
    nxt_busy = (nxt != IDLE) && (nxt != FIN);
    nxt_addr = (nxt_wr || nxt_rd) ? nxt_cnt : '0;
    nxt_exp  = (nxt == M2_RD) ? P1 : P0;
    nxt_din  = '0;
    if (nxt == M0 || nxt == M2_WR) nxt_din = P0;
    if (nxt == M1_WR)              nxt_din = P1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      WR        <= 1'b0;
      address   <= '0;
      Din       <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_DATA <= '0;
      ERR_COUNT <= '0;
      rd_v      <= 1'b0;
      rd_a      <= '0;
      rd_e      <= '0;
    end else begin
      state   <= nxt;
      cnt     <= nxt_cnt;
      WR      <= nxt_wr;
      address <= nxt_addr;
      Din     <= nxt_din;
      BUSY    <= nxt_busy;
      rd_v    <= nxt_rd;
      rd_a    <= nxt_addr;
      rd_e    <= nxt_exp;
      if (nxt == FIN) DONE <= 1'b1;
      if (cmp_v && (Dout != cmp_e)) begin
        if (!FAIL) begin
          FAIL_ADDR <= cmp_a;
          FAIL_DATA <= Dout ^ cmp_e;
        end
        FAIL <= 1'b1;
        if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
      end
      if (state == IDLE && START) begin
        DONE      <= 1'b0;
        FAIL      <= 1'b0;
        FAIL_ADDR <= '0;
        FAIL_DATA <= '0;
        ERR_COUNT <= '0;
      end
    end
  end

  generate
    if (RD_LAT == 0) begin : g_nopipe
      assign cmp_v = rd_v;
      assign cmp_a = rd_a;
      assign cmp_e = rd_e;
    end else begin : g_pipe
      logic [RD_LAT-1:0] pv;
      logic [ADDR_W-1:0] pa [RD_LAT];
      logic [DATA_W-1:0] pe [RD_LAT];
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          pv <= '0;
          for (int i = 0; i < RD_LAT; i++) begin
            pa[i] <= '0;
            pe[i] <= '0;
          end
        end else begin
          pv[0] <= rd_v;
          pa[0] <= rd_a;
          pe[0] <= rd_e;
          for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end
      assign cmp_v = pv[RD_LAT-1];
      assign cmp_a = pa[RD_LAT-1];
      assign cmp_e = pe[RD_LAT-1];
    end
  endgenerate

endmodule
